// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding and
// default widths for the PC, lookup index and cycle counter.
package pc_pkg;

    localparam int PC_D  = 10;
    localparam int PC_IW = 5;
    localparam int PC_CW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pc_seq.sv
// Program-counter sequencer: steps, branches, holds or halts the PC and counts RUN
// cycles. Define PC_LINK_EN to add a one-entry link register for call/ret.
module pc_seq
    import pc_pkg::*;
#(
    parameter int D  = PC_D,
    parameter int IW = PC_IW,
    parameter int CW = PC_CW
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          stall,
    input  logic          halt,
    input  logic          branch_en,
    input  logic [IW-1:0] branch_idx,
    output logic [IW-1:0] lut_addr,
    input  logic [D-1:0]  lut_target,
    input  logic          call,
    input  logic          ret,
    output logic [D-1:0]  pc,
    output logic          running,
    output logic          done,
    output logic          wrap_err,
    output logic [CW-1:0] cycle_cnt
);

    state_e        state_q;
    logic [D-1:0]  pc_q;
    logic [CW-1:0] cnt_q;
    logic          running_q;
    logic          done_q;
    logic          wrap_q;

    logic [D-1:0]  pc_inc_d;
    logic [D-1:0]  pc_run_d;
    logic          wrap_run_d;
    logic [CW-1:0] cnt_d;

    assign lut_addr = branch_idx;
    assign pc_inc_d = pc_q + 1'b1;
    assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef PC_LINK_EN
    logic [D-1:0] link_q;
    logic         link_vld_q;
    logic         link_adv;

    // ret outranks call and branch even when the link is empty: it then just increments.
    always_comb begin
        pc_run_d   = pc_inc_d;
        wrap_run_d = (pc_q == '1);
        if (ret) begin
            if (link_vld_q) begin
                pc_run_d   = link_q;
                wrap_run_d = 1'b0;
            end
        end else if (call || branch_en) begin
            pc_run_d   = lut_target;
            wrap_run_d = 1'b0;
        end
    end

    assign link_adv = !start && (state_q == RUN) && !stall && !halt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            link_q     <= '0;
            link_vld_q <= 1'b0;
        end else if (start) begin
            link_vld_q <= 1'b0;
        end else if (link_adv) begin
            if (ret) begin
                link_vld_q <= 1'b0;
            end else if (call) begin
                link_q     <= pc_inc_d;
                link_vld_q <= 1'b1;
            end
        end
    end
`else
    logic unused_ret;
    assign unused_ret = ret;

    always_comb begin
        pc_run_d   = pc_inc_d;
        wrap_run_d = (pc_q == '1);
        if (branch_en || call) begin
            pc_run_d   = lut_target;
            wrap_run_d = 1'b0;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else if (start) begin
            state_q   <= RUN;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    cnt_q <= cnt_d;
                    if (stall) begin
                        pc_q <= pc_q;
                    end else if (halt) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        pc_q <= pc_run_d;
                        if (wrap_run_d) wrap_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign pc        = pc_q;
    assign running   = running_q;
    assign done      = done_q;
    assign wrap_err  = wrap_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus randomized traffic
// compared against a behavioural model. Honours PC_LINK_EN when defined.
module tb_pc_seq;

    localparam int D      = 10;
    localparam int IW     = 5;
    localparam int CW     = 6;
    localparam int PC_MOD = 1 << D;
    localparam int CNT_MX = (1 << CW) - 1;

    logic          Clk;
    logic          Reset_n;
    logic          start, stall, halt, branch_en, call, ret;
    logic [IW-1:0] branch_idx;
    logic [IW-1:0] lut_addr;
    logic [D-1:0]  lut_target;
    logic [D-1:0]  pc;
    logic          running, done, wrap_err;
    logic [CW-1:0] cycle_cnt;

    logic [D-1:0]  lut [32];

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state
    int m_pc, m_cnt, m_link;
    bit m_run, m_done, m_wrap, m_lv;

    pc_seq #(.D(D), .IW(IW), .CW(CW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .stall      (stall),
        .halt       (halt),
        .branch_en  (branch_en),
        .branch_idx (branch_idx),
        .lut_addr   (lut_addr),
        .lut_target (lut_target),
        .call       (call),
        .ret        (ret),
        .pc         (pc),
        .running    (running),
        .done       (done),
        .wrap_err   (wrap_err),
        .cycle_cnt  (cycle_cnt)
    );

    assign lut_target = lut[lut_addr];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_wrap = 0; m_lv = 0; m_link = 0;
    endtask

    // One rising edge worth of the sequencing rules, using the inputs present at the edge.
    task automatic model_edge();
        int nxt;
        if (start) begin
            m_pc = 0; m_wrap = 0; m_cnt = 0; m_run = 1; m_done = 0; m_lv = 0;
        end else if (m_run) begin
            m_cnt = (m_cnt < CNT_MX) ? m_cnt + 1 : CNT_MX;
            if (stall) begin
                nxt = m_pc;
            end else if (halt) begin
                m_run = 0; m_done = 1;
            end else begin
                nxt = m_pc + 1;
`ifdef PC_LINK_EN
                if (ret) begin
                    if (m_lv) begin nxt = m_link; m_lv = 0; end
                end else if (call) begin
                    m_link = (m_pc + 1) % PC_MOD;
                    m_lv   = 1;
                    nxt    = int'(lut[branch_idx]);
                end else if (branch_en) begin
                    nxt = int'(lut[branch_idx]);
                end
`else
                if (branch_en || call) nxt = int'(lut[branch_idx]);
`endif
                if (nxt == PC_MOD) m_wrap = 1;
                m_pc = nxt % PC_MOD;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},      32'(pc),        32'(m_pc));
        check({tag, ".running"}, 32'(running),   32'(m_run));
        check({tag, ".done"},    32'(done),      32'(m_done));
        check({tag, ".wrap"},    32'(wrap_err),  32'(m_wrap));
        check({tag, ".cnt"},     32'(cycle_cnt), 32'(m_cnt));
        check({tag, ".lut_addr"}, 32'(lut_addr), 32'(branch_idx));
    endtask

    task automatic set_in(input bit st, input bit sl, input bit h, input bit b,
                          input int idx, input bit c, input bit r);
        start = st; stall = sl; halt = h; branch_en = b;
        branch_idx = IW'(idx); call = c; ret = r;
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) lut[i] = D'($urandom);
        lut[1] = D'(19);
        lut[2] = D'(1023);
        lut[3] = D'(35);
        lut[4] = D'(12);
        lut[5] = D'(40);

        set_in(0, 0, 0, 0, 0, 0, 0);
        Reset_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Start, then four plain increments.
        set_in(1, 0, 0, 0, 0, 0, 0); step("start");
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("inc");
        check("pc_after4", 32'(pc), 32'd4);
        check("cnt_after4", 32'(cycle_cnt), 32'd4);
        check("running_after4", 32'(running), 32'd1);

        // Reach pc=7, branch through index 3, then stall.
        for (int i = 0; i < 3; i++) step("inc7");
        set_in(0, 0, 0, 1, 3, 0, 0);
        #0 check("lut_addr_idx3", 32'(lut_addr), 32'd3);
        step("branch3");
        check("pc_branch35", 32'(pc), 32'd35);
        set_in(0, 1, 0, 0, 3, 0, 0); step("stall");
        check("pc_stall35", 32'(pc), 32'd35);

        // Halt at pc=12, ignored pulses in DONE, then restart.
        set_in(0, 0, 0, 1, 4, 0, 0); step("branch12");
        set_in(0, 0, 1, 0, 0, 0, 0); step("halt");
        check("done_halt", 32'(done), 32'd1);
        check("pc_halt12", 32'(pc), 32'd12);
        set_in(0, 1, 0, 1, 3, 1, 1); step("done_ign0");
        set_in(0, 0, 1, 1, 2, 0, 0); step("done_ign1");
        set_in(0, 0, 0, 0, 0, 0, 0); step("done_ign2");
        set_in(1, 1, 1, 1, 3, 1, 1); step("restart");

        // Wrap from 1023 to 0, then clear with start.
        set_in(0, 0, 0, 1, 2, 0, 0); step("branch1023");
        set_in(0, 0, 0, 0, 0, 0, 0); step("wrap");
        check("pc_wrap0", 32'(pc), 32'd0);
        check("wrap_set", 32'(wrap_err), 32'd1);
        step("wrap_sticky");
        set_in(1, 0, 0, 0, 0, 0, 0); step("wrap_clear");
        check("wrap_cleared", 32'(wrap_err), 32'd0);

        // Async reset mid-run at pc=40.
        set_in(0, 0, 0, 1, 5, 0, 0); step("branch40");
        set_in(0, 0, 0, 0, 0, 0, 0);
        async_reset("midrun_rst");
        set_in(0, 1, 1, 1, 3, 1, 1); step("idle_ign0");
        set_in(0, 0, 0, 1, 3, 0, 0); step("idle_ign1");

        // Call/ret sequence from pc=5.
        set_in(1, 0, 0, 0, 0, 0, 0); step("start_link");
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("inc5");
        set_in(0, 0, 0, 0, 1, 1, 0); step("call");
        check("pc_call19", 32'(pc), 32'd19);
        set_in(0, 0, 0, 0, 0, 0, 1); step("ret1");
`ifdef PC_LINK_EN
        check("pc_ret6", 32'(pc), 32'd6);
`else
        check("pc_ret20", 32'(pc), 32'd20);
`endif
        step("ret2");
`ifdef PC_LINK_EN
        check("pc_ret7", 32'(pc), 32'd7);
`else
        check("pc_ret21", 32'(pc), 32'd21);
`endif

        // Randomized traffic, including counter saturation and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            set_in($urandom_range(299) == 0,
                   $urandom_range(3) == 0,
                   $urandom_range(149) == 0,
                   $urandom_range(5) == 0,
                   int'($urandom_range(31)),
                   $urandom_range(9) == 0,
                   $urandom_range(9) == 0);
            if ($urandom_range(799) == 0) async_reset("rnd_rst");
            else step("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Program-counter sequencer for the 9-bit processor; the initiator side of the branch-target lookup.
- Drives a 5-bit lookup index to the combinational PC lookup table and consumes the D-bit target in the same cycle.
- Each clock it advances, branches, holds or halts the PC.
- Reports run status and a cycle count for program benchmarking.

Parameters:
- D, 10, PC / instruction-address width
- IW, 5, lookup-table index width (32 entries)
- CW, 16, cycle-counter width

Ports:
- Clk  input  1  single system clock, rising edge
- Reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: PC<=0, begin running
- stall  input  1  hold PC this cycle (memory/ALU busy)
- halt  input  1  current instruction is halt
- branch_en  input  1  taken branch this cycle
- branch_idx  input  IW  lookup index from instruction
- lut_addr  output  IW  index to lookup table; combinational copy of branch_idx
- lut_target  input  D  target returned by lookup table (combinational, same cycle)
- call  input  1  taken branch that saves return address (feature only)
- ret  input  1  return to saved address (feature only)
- pc  output  D  registered program counter
- running  output  1  FSM in RUN
- done  output  1  FSM in DONE
- wrap_err  output  1  sticky: PC wrapped past 2^D-1
- cycle_cnt  output  CW  RUN cycles since last start

Behaviour:
- Reset (async, Reset_n=0): pc=0, state IDLE, running=0, done=0, wrap_err=0, cycle_cnt=0; link register cleared/invalid.
- Reset mid-run aborts immediately; no pending update survives.
- FSM states:
  - IDLE: wait for start.
  - RUN: sequence PC.
  - DONE: hold pc, done=1.
- start in any state: pc<=0, wrap_err<=0, cycle_cnt<=0, next state RUN. start overrides every other input that cycle.
- RUN priority, evaluated each rising edge: start > stall > halt > ret > call/branch_en > increment.
  - stall: pc holds; cycle_cnt still increments.
  - halt (not stalled): pc holds, next state DONE, cycle_cnt increments for this final cycle.
  - branch_en or call: pc<=lut_target; target latency zero (index and target resolve in the same cycle).
  - otherwise pc<=pc+1, modulo 2^D. Wrap from 2^D-1 to 0 sets wrap_err (sticky until start or reset).
- cycle_cnt saturates at 2^CW-1; it never wraps.
- In IDLE and DONE, branch, stall, halt, call and ret are ignored; cycle_cnt frozen.
- running and done are registered state decodes: mutually exclusive, both 0 in IDLE.
- lut_addr=branch_idx at all times, regardless of state.

Optional Feature:
- Macro PC_LINK_EN.
- Defined: one-entry link register.
  - call in RUN (unstalled): link<=pc+1 (mod 2^D), link valid, pc<=lut_target.
  - ret: if link valid, pc<=link and link invalidated; if invalid, treated as plain increment.
  - call and ret together: ret wins, call ignored.
- Undefined: call treated exactly as branch_en; ret ignored; no link storage synthesized.

Decomposition:
- Shared package pc_pkg: state enum (IDLE, RUN, DONE), default D/IW/CW constants.
- Single module; no sub-module warranted. The lookup table is instantiated beside pc_seq by the top level, not inside it.

Test Plan:
- Reset then start; no branches for 4 cycles -> pc 0,1,2,3,4; running=1; cycle_cnt=4.
- Bench table 3->35: branch_en=1, branch_idx=3 at pc=7 -> lut_addr=3, next pc=35; stall on the following cycle -> pc stays 35, cycle_cnt still increments.
- halt at pc=12 -> pc holds 12, done=1, running=0. Further branch/stall pulses -> no change. start -> pc=0, RUN.
- Force pc to 1023 (branch to index with target 1023), then one increment -> pc=0, wrap_err=1; start -> wrap_err=0.
- Reset_n low mid-run at pc=40 -> pc=0, IDLE, all outputs 0 asynchronously, before the next clock edge.
- With PC_LINK_EN: call idx 1 (target 19) at pc=5 -> pc=19; ret -> pc=6. Second ret -> pc=7 (link invalid). Without the macro, the same call -> pc=19 and ret -> pc=20.
